// File: rtl/store_word_bank.sv
// Addressed word bank: byte-masked writes, per-entry written flags, 1-cycle registered reads,
// and a post-reset clear sequencer. Optional same-address forwarding: STORE_WORD_BANK_BYPASS_EN.
module store_word_bank #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_enable,
    input  logic [ADDR_W-1:0]    write_addr,
    input  logic [WIDTH/8-1:0]   write_mask,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 read_enable,
    input  logic [ADDR_W-1:0]    read_addr,
    output logic [WIDTH-1:0]     data_out,
    output logic                 output_enable,
    output logic                 read_valid,
    output logic                 busy
);

    localparam int LANES = WIDTH / 8;
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    generate
        if ((WIDTH % 8) != 0) begin : g_bad_width
            $error("store_word_bank: WIDTH must be a multiple of 8");
        end
        if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
            $error("store_word_bank: ADDR_W too narrow for DEPTH");
        end
        if ((DEPTH < 2) || (DEPTH > 256)) begin : g_bad_depth
            $error("store_word_bank: DEPTH must be in 2..256");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clear_ptr;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH-1:0]    written;

    logic                wr_ok;
    logic                rd_in_range;
    logic [WIDTH-1:0]    wr_word;
    logic [WIDTH-1:0]    rd_word;
    logic                rd_flag;

    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [LANES-1:0] mask
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Address qualification, merged write word and the word/flag a read would capture.
    always_comb begin
        wr_ok       = (state == ST_IDLE) && write_enable && ({1'b0, write_addr} < DEPTH_LIM);
        rd_in_range = ({1'b0, read_addr} < DEPTH_LIM);
        wr_word     = '0;
        rd_word     = '0;
        rd_flag     = 1'b0;
        if (wr_ok) begin
            wr_word = merge_lanes(mem[write_addr], data_in, write_mask);
        end else begin
            wr_word = '0;
        end
        if (rd_in_range) begin
`ifdef STORE_WORD_BANK_BYPASS_EN
            if (wr_ok && (write_addr == read_addr)) begin
                rd_word = wr_word;
                rd_flag = 1'b1;
            end else begin
                rd_word = mem[read_addr];
                rd_flag = written[read_addr];
            end
`else
            rd_word = mem[read_addr];
            rd_flag = written[read_addr];
`endif
        end else begin
            rd_word = '0;
            rd_flag = 1'b0;
        end
    end

    // Storage array: zeroed one entry per cycle while clearing, then written by masked stores.
    always_ff @(posedge clk) begin
        if (rst && (state == ST_CLEAR)) begin
            mem[clear_ptr] <= '0;
        end else if (rst && wr_ok) begin
            mem[write_addr] <= wr_word;
        end
    end

    // Sequencer, written flags and registered read port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_CLEAR;
            clear_ptr     <= '0;
            busy          <= 1'b1;
            data_out      <= '0;
            output_enable <= 1'b0;
            read_valid    <= 1'b0;
            written       <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    data_out      <= '0;
                    output_enable <= 1'b0;
                    read_valid    <= 1'b0;
                    if (clear_ptr == LAST_IDX) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        clear_ptr <= '0;
                    end else begin
                        busy      <= 1'b1;
                        clear_ptr <= clear_ptr + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (wr_ok) begin
                        written[write_addr] <= 1'b1;
                    end
                    // Out-of-range reads still complete, returning zero and an invalid flag.
                    if (read_enable) begin
                        data_out      <= rd_word;
                        read_valid    <= rd_flag;
                        output_enable <= 1'b1;
                    end else begin
                        read_valid    <= 1'b0;
                        output_enable <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_CLEAR;
                    clear_ptr <= '0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_word_bank.sv
// Self-checking bench for store_word_bank: table of vectors through a latency-1 scoreboard,
// plus hand-written reset/clear and small-depth out-of-range sequences.
module tb_store_word_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we, re;
    logic [3:0]  wa, ra;
    logic [1:0]  wm;
    logic [15:0] wd, dout;
    logic        oe, rv, busy;

    logic        we12, re12;
    logic [3:0]  wa12, ra12;
    logic [1:0]  wm12;
    logic [15:0] wd12, dout12;
    logic        oe12, rv12, busy12;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    store_word_bank #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .write_enable(we), .write_addr(wa), .write_mask(wm), .data_in(wd),
        .read_enable(re), .read_addr(ra),
        .data_out(dout), .output_enable(oe), .read_valid(rv), .busy(busy)
    );

    store_word_bank #(.WIDTH(16), .DEPTH(12), .ADDR_W(4)) dut12 (
        .clk(clk), .rst(rst),
        .write_enable(we12), .write_addr(wa12), .write_mask(wm12), .data_in(wd12),
        .read_enable(re12), .read_addr(ra12),
        .data_out(dout12), .output_enable(oe12), .read_valid(rv12), .busy(busy12)
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  wa;
        logic [1:0]  wm;
        logic [15:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic [15:0] exp_data;
        logic        exp_oe;
        logic        exp_valid;
    } vec_t;

    vec_t sb[$];

    function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [1:0] m,
                                input logic [15:0] d, input logic r, input logic [3:0] b,
                                input logic [15:0] ed, input logic eo, input logic ev);
        vec_t v;
        v = '{we: w, wa: a, wm: m, wd: d, re: r, ra: b, exp_data: ed, exp_oe: eo, exp_valid: ev};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = 4'd0; wm = 2'd0; wd = 16'h0000; re = 1'b0; ra = 4'd0;
    endtask

    // Drive one vector, queue its expectation, then pop and compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        we = v.we; wa = v.wa; wm = v.wm; wd = v.wd; re = v.re; ra = v.ra;
        sb.push_back(v);
        tick();
        e = sb.pop_front();
        check({tag, ".data"},  {16'h0000, dout}, {16'h0000, e.exp_data});
        check({tag, ".oe"},    {31'd0, oe},      {31'd0, e.exp_oe});
        check({tag, ".valid"}, {31'd0, rv},      {31'd0, e.exp_valid});
        idle_inputs();
    endtask

    // One-cycle reset, then count busy cycles while attempting ignored traffic.
    task automatic reset_and_clear(input string tag);
        int cnt, cnt12;
        logic oe_seen;
        idle_inputs();
        rst = 1'b0;
        tick();
        check({tag, ".rst_busy"},  {31'd0, busy},     32'd1);
        check({tag, ".rst_oe"},    {31'd0, oe},       32'd0);
        check({tag, ".rst_valid"}, {31'd0, rv},       32'd0);
        check({tag, ".rst_data"},  {16'h0000, dout},  32'd0);
        rst = 1'b1;
        we = 1'b1; wa = 4'd7; wm = 2'b11; wd = 16'h1111; re = 1'b1; ra = 4'd7;
        cnt = 1; cnt12 = 1; oe_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (busy)   cnt++;
            if (busy12) cnt12++;
            if (oe)     oe_seen = 1'b1;
            if (!busy) break;
        end
        idle_inputs();
        check({tag, ".busy_cycles"},   cnt,   32'd16);
        check({tag, ".busy12_cycles"}, cnt12, 32'd12);
        check({tag, ".oe_while_busy"}, {31'd0, oe_seen}, 32'd0);
    endtask

    vec_t vecs[17];

    initial begin
        idle_inputs();
        we12 = 1'b0; wa12 = 4'd0; wm12 = 2'd0; wd12 = 16'h0000; re12 = 1'b0; ra12 = 4'd0;

        vecs[0]  = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd5,  16'h0000, 1'b1, 1'b0);
        vecs[1]  = mk(1'b1, 4'd3,  2'b11, 16'hAAAA, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd3,  16'hAAAA, 1'b1, 1'b1);
        vecs[3]  = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b0, 4'd0,  16'hAAAA, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 4'd3,  2'b01, 16'h1234, 1'b0, 4'd0,  16'hAAAA, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd3,  16'hAA34, 1'b1, 1'b1);
`ifdef STORE_WORD_BANK_BYPASS_EN
        vecs[6]  = mk(1'b1, 4'd3,  2'b11, 16'h5555, 1'b1, 4'd3,  16'h5555, 1'b1, 1'b1);
`else
        vecs[6]  = mk(1'b1, 4'd3,  2'b11, 16'h5555, 1'b1, 4'd3,  16'hAA34, 1'b1, 1'b1);
`endif
        vecs[7]  = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd3,  16'h5555, 1'b1, 1'b1);
        vecs[8]  = mk(1'b1, 4'd9,  2'b00, 16'hFFFF, 1'b0, 4'd0,  16'h5555, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd9,  16'h0000, 1'b1, 1'b1);
`ifdef STORE_WORD_BANK_BYPASS_EN
        vecs[10] = mk(1'b1, 4'd12, 2'b10, 16'hC3C3, 1'b1, 4'd12, 16'hC300, 1'b1, 1'b1);
`else
        vecs[10] = mk(1'b1, 4'd12, 2'b10, 16'hC3C3, 1'b1, 4'd12, 16'h0000, 1'b1, 1'b0);
`endif
        vecs[11] = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd12, 16'hC300, 1'b1, 1'b1);
        vecs[12] = mk(1'b1, 4'd7,  2'b11, 16'hBEEF, 1'b1, 4'd3,  16'h5555, 1'b1, 1'b1);
        vecs[13] = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd7,  16'hBEEF, 1'b1, 1'b1);
        vecs[14] = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd15, 16'h0000, 1'b1, 1'b0);
        vecs[15] = mk(1'b1, 4'd15, 2'b10, 16'hABCD, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd15, 16'hAB00, 1'b1, 1'b1);

        reset_and_clear("init");
        for (int i = 0; i < 17; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Mid-traffic reset must wipe contents and flags; the write issued while busy is dropped.
        reset_and_clear("rerst");
        apply(mk(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 16'h0000, 1'b1, 1'b0), "post7");
        apply(mk(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd3, 16'h0000, 1'b1, 1'b0), "post3");

        // DEPTH=12 instance: out-of-range write/read and top-entry read.
        we12 = 1'b1; wa12 = 4'd2; wm12 = 2'b11; wd12 = 16'h7E7E;
        tick();
        we12 = 1'b0; re12 = 1'b1; ra12 = 4'd2;
        tick();
        check("d12.rd2_data",  {16'h0000, dout12}, 32'h7E7E);
        check("d12.rd2_valid", {31'd0, rv12},      32'd1);
        re12 = 1'b0; we12 = 1'b1; wa12 = 4'd13; wd12 = 16'hFFFF;
        tick();
        check("d12.wr13_oe", {31'd0, oe12}, 32'd0);
        we12 = 1'b0; re12 = 1'b1; ra12 = 4'd13;
        tick();
        check("d12.rd13_data",  {16'h0000, dout12}, 32'h0000);
        check("d12.rd13_oe",    {31'd0, oe12},      32'd1);
        check("d12.rd13_valid", {31'd0, rv12},      32'd0);
        ra12 = 4'd11;
        tick();
        check("d12.rd11_data",  {16'h0000, dout12}, 32'h0000);
        check("d12.rd11_oe",    {31'd0, oe12},      32'd1);
        check("d12.rd11_valid", {31'd0, rv12},      32'd0);
        re12 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
